robot_motion_sequencer: RTL and testbench
=========================================

Name: robot_motion_sequencer

Overview:
- Sits between the wall-following decision logic (outputs front/turn) and the motor drivers.
- Accepts one move command per step via a valid/ready handshake.
- Sequences timed motor-enable phases for each move: left 90° pivot, forward step, or turn-then-forward.
- Tracks absolute heading and flags a "stuck" condition when the robot rotates a full circle without advancing.

Parameters:
- FWD_TICKS, 4: cycles motors run for one forward step; minimum 1.
- TURN_TICKS, 3: cycles motors run for one 90° left pivot; minimum 1.
- SETTLE_TICKS, 2: motors-off cycles after each motion phase; minimum 1.
- CNT_W, 8: phase counter width. Every *_TICKS value must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_front  in  1  request one forward step.
- cmd_turn  in  1  request one 90° left pivot.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- motor_l_en  out  1  left motor enable, registered.
- motor_l_dir  out  1  left motor direction (1 = forward, 0 = reverse), registered.
- motor_r_en  out  1  right motor enable, registered.
- motor_r_dir  out  1  right motor direction, registered.
- busy  out  1  high whenever state is not IDLE.
- step_done  out  1  one-cycle pulse when a command completes.
- heading  out  2  0 = N, 1 = W, 2 = S, 3 = E.
- stuck  out  1  four or more consecutive completed turns with no forward step.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; counter, turn_count and heading = 0.
  - All motor outputs, step_done and stuck = 0.
  - Reset asserted mid-motion drops the motors in the same instant; the in-flight command is discarded and heading is not updated.
- States: IDLE, TURN, FWD, SETTLE.
- Acceptance: a command is accepted when cmd_valid && cmd_ready at a rising edge. cmd_front/cmd_turn are captured at that edge; later input changes are ignored until the next IDLE.
- Transitions from IDLE on acceptance:
  - turn = 1 → TURN. If front is also 1, a pending_fwd flag is set.
  - front = 1 only → FWD.
  - Both 0 → no-op: state stays IDLE, step_done pulses on the next cycle, heading and turn_count are unchanged.
- TURN:
  - Outputs: motor_l_en = 1, motor_l_dir = 0, motor_r_en = 1, motor_r_dir = 1.
  - Lasts exactly TURN_TICKS cycles, starting the cycle after acceptance.
  - On exit: heading increments mod 4 (3 → 0 wraps); turn_count increments and saturates at 4.
  - Then → SETTLE.
- FWD:
  - Outputs: both enables = 1, both directions = 1.
  - Lasts exactly FWD_TICKS cycles.
  - On exit: turn_count clears to 0 and stuck deasserts.
  - Then → SETTLE.
- SETTLE:
  - Motors off: enables 0, directions hold their last values.
  - Lasts SETTLE_TICKS cycles.
  - If pending_fwd is set: clear it and go to FWD.
  - Otherwise: go to IDLE with step_done = 1 for the first IDLE cycle. A new command may be accepted in that same cycle.
- stuck: registered, equal to (turn_count == 4). It becomes visible the cycle after the fourth consecutive turn completes.
- Step latency:
  - Pure forward: FWD_TICKS + SETTLE_TICKS cycles from acceptance to the step_done cycle.
  - Turn + forward: TURN_TICKS + FWD_TICKS + 2·SETTLE_TICKS cycles.
- No gaps between phases: motor enables never glitch between consecutive phases.
- busy is registered alongside state.

Test Plan:
- Reset, then a single command front=1, turn=0 accepted at cycle 0 → motors on for cycles 1–4 (dirs 1/1), off for cycles 5–6, step_done = 1 at cycle 7, heading stays 0.
- Command turn=1, front=0 → motor_l_dir = 0 and motor_r_dir = 1 with both enabled for 3 cycles, then 2 settle cycles; heading becomes 1 and step_done pulses at cycle 6.
- Command front=1, turn=1 → 3 turn cycles, 2 settle, 4 forward, 2 settle; step_done at cycle 12, heading 1, turn_count back to 0.
- Four consecutive turn-only commands from heading 3 → heading sequence 0, 1, 2, 3 (wrap from 3 checked); stuck = 1 after the fourth turn. A following forward command clears stuck at the end of its FWD phase.
- Command front=0, turn=0 → no motor activity; step_done pulses on the next cycle; busy stays 0.
- Deassert rst_n during cycle 2 of FWD → all enables drop immediately; after release the state is IDLE, cmd_ready = 1, heading is unchanged from its pre-reset value of 0, and step_done never pulses.

Source files
------------

// File: rtl/robot_motion_sequencer.sv
// Turns one front/turn move command into timed motor phases (TURN, FWD, SETTLE) and tracks heading/stuck.
// Motors switch the cycle after acceptance; step_done marks the first IDLE cycle; cmd_ready is high only in IDLE.
module robot_motion_sequencer #(
    parameter int FWD_TICKS    = 4,
    parameter int TURN_TICKS   = 3,
    parameter int SETTLE_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       cmd_front,
    input  logic       cmd_turn,
    output logic       cmd_ready,
    output logic       motor_l_en,
    output logic       motor_l_dir,
    output logic       motor_r_en,
    output logic       motor_r_dir,
    output logic       busy,
    output logic       step_done,
    output logic [1:0] heading,
    output logic       stuck
);

    typedef enum logic [1:0] {IDLE, TURN, FWD, SETTLE} state_t;

    localparam logic [CNT_W-1:0] FWD_LAST    = CNT_W'(FWD_TICKS - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [2:0]       turn_count_q, turn_count_d;
    logic [1:0]       heading_q, heading_d;
    logic             pending_fwd_q, pending_fwd_d;
    logic             l_en_d, l_dir_d, r_en_d, r_dir_d;
    logic             step_done_d, stuck_d;

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q + 1'b1;
        turn_count_d  = turn_count_q;
        heading_d     = heading_q;
        pending_fwd_d = pending_fwd_q;
        step_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (cmd_valid) begin
                    if (cmd_turn) begin
                        state_d       = TURN;
                        pending_fwd_d = cmd_front;
                    end else if (cmd_front) begin
                        state_d = FWD;
                    end else begin
                        step_done_d = 1'b1;
                    end
                end
            end
            TURN: begin
                if (counter_q == TURN_LAST) begin
                    state_d      = SETTLE;
                    counter_d    = '0;
                    heading_d    = heading_q + 2'd1;
                    turn_count_d = (turn_count_q == 3'd4) ? 3'd4 : turn_count_q + 3'd1;
                end
            end
            FWD: begin
                if (counter_q == FWD_LAST) begin
                    state_d      = SETTLE;
                    counter_d    = '0;
                    turn_count_d = '0;
                end
            end
            SETTLE: begin
                if (counter_q == SETTLE_LAST) begin
                    counter_d = '0;
                    if (pending_fwd_q) begin
                        pending_fwd_d = 1'b0;
                        state_d       = FWD;
                    end else begin
                        state_d     = IDLE;
                        step_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Motor outputs follow the next state so they register together with it.
        l_en_d  = 1'b0;
        r_en_d  = 1'b0;
        l_dir_d = motor_l_dir;
        r_dir_d = motor_r_dir;
        if (state_d == TURN) begin
            l_en_d  = 1'b1;
            r_en_d  = 1'b1;
            l_dir_d = 1'b0;
            r_dir_d = 1'b1;
        end else if (state_d == FWD) begin
            l_en_d  = 1'b1;
            r_en_d  = 1'b1;
            l_dir_d = 1'b1;
            r_dir_d = 1'b1;
        end

        stuck_d = (turn_count_d == 3'd4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            turn_count_q  <= '0;
            heading_q     <= '0;
            pending_fwd_q <= 1'b0;
            busy          <= 1'b0;
            step_done     <= 1'b0;
            stuck         <= 1'b0;
            motor_l_en    <= 1'b0;
            motor_l_dir   <= 1'b0;
            motor_r_en    <= 1'b0;
            motor_r_dir   <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            turn_count_q  <= turn_count_d;
            heading_q     <= heading_d;
            pending_fwd_q <= pending_fwd_d;
            busy          <= (state_d != IDLE);
            step_done     <= step_done_d;
            stuck         <= stuck_d;
            motor_l_en    <= l_en_d;
            motor_l_dir   <= l_dir_d;
            motor_r_en    <= r_en_d;
            motor_r_dir   <= r_dir_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign heading   = heading_q;

endmodule

// File: tb/tb_robot_motion_sequencer.sv
// Directed + random command sequences checked cycle by cycle against a phase-list model of the sequencer.
module tb_robot_motion_sequencer;

    localparam int FT = 4;
    localparam int TT = 3;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_front, cmd_turn;
    logic       cmd_ready, motor_l_en, motor_l_dir, motor_r_en, motor_r_dir;
    logic       busy, step_done, stuck;
    logic [1:0] heading;
    logic [9:0] obs;

    robot_motion_sequencer #(
        .FWD_TICKS(FT), .TURN_TICKS(TT), .SETTLE_TICKS(ST), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_front(cmd_front), .cmd_turn(cmd_turn),
        .cmd_ready(cmd_ready),
        .motor_l_en(motor_l_en), .motor_l_dir(motor_l_dir),
        .motor_r_en(motor_r_en), .motor_r_dir(motor_r_dir),
        .busy(busy), .step_done(step_done), .heading(heading), .stuck(stuck)
    );

    always #5 clk = ~clk;

    assign obs = {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir,
                  busy, step_done, cmd_ready, stuck, heading};

    int tests = 0;
    int fails = 0;

    // Reference state: what the robot should know about itself.
    logic [1:0] m_head;
    int         m_tc;
    logic       m_stuck, m_ld, m_rd;
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [9:0] ev(input bit le, input bit re, input bit bsy,
                                      input bit sd, input bit rdy);
        return {le, m_ld, re, m_rd, bsy, sd, rdy, m_stuck, m_head};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One motion phase followed by its settle period; heading/turn bookkeeping lands at the phase end.
    task automatic push_phase(input bit is_turn, input int n);
        m_ld = is_turn ? 1'b0 : 1'b1;
        m_rd = 1'b1;
        repeat (n) exp_q.push_back(ev(1, 1, 1, 0, 0));
        if (is_turn) begin
            m_head = m_head + 2'd1;
            if (m_tc < 4) m_tc++;
        end else begin
            m_tc = 0;
        end
        m_stuck = (m_tc == 4);
        repeat (ST) exp_q.push_back(ev(0, 0, 1, 0, 0));
    endtask

    task automatic model_reset();
        m_head = 2'd0; m_tc = 0; m_stuck = 1'b0; m_ld = 1'b0; m_rd = 1'b0;
    endtask

    task automatic do_cmd(input bit f, input bit t, input string tag);
        cmd_valid = 1'b1; cmd_front = f; cmd_turn = t;
        exp_q.delete();
        if (t) push_phase(1'b1, TT);
        if (f) push_phase(1'b0, FT);
        exp_q.push_back(ev(0, 0, 0, 1, 1));
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
            if (i == exp_q.size() - 1) begin
                cmd_valid = 1'b0;
            end else begin
                // Input noise while busy must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_front = 1'($urandom_range(0, 1));
                cmd_turn  = 1'($urandom_range(0, 1));
                tick();
            end
        end
    endtask

    task automatic gap(input int n, input string tag);
        cmd_valid = 1'b0;
        repeat (n) begin
            tick();
            chk(tag, obs, ev(0, 0, 0, 0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_front = 1'b0; cmd_turn = 1'b0;
        model_reset();
        tick(); tick();
        chk("reset", obs, ev(0, 0, 0, 0, 1));
        @(negedge clk) rst_n = 1'b1;
        gap(2, "post_reset");

        do_cmd(1'b1, 1'b0, "fwd");
        gap(1, "gap");

        // Reset asserted during the second FWD cycle.
        cmd_valid = 1'b1; cmd_front = 1'b1; cmd_turn = 1'b0;
        m_ld = 1'b1; m_rd = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rst_fwd_c1", obs, ev(1, 1, 1, 0, 0));
        tick();
        chk("rst_fwd_c2", obs, ev(1, 1, 1, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_drop", obs, ev(0, 0, 0, 0, 1));
        @(negedge clk) rst_n = 1'b1;
        gap(FT + ST + 2, "rst_no_done");

        do_cmd(1'b1, 1'b1, "turn_fwd");
        do_cmd(1'b0, 1'b1, "turn_a");
        gap(2, "gap");
        do_cmd(1'b0, 1'b1, "turn_b");
        do_cmd(1'b1, 1'b0, "fwd_clr");
        for (int k = 0; k < 4; k++) do_cmd(1'b0, 1'b1, $sformatf("turn4_%0d", k));
        chk("stuck_after_4", {30'd0, stuck}, 32'd1);
        do_cmd(1'b1, 1'b0, "fwd_unstuck");
        do_cmd(1'b0, 1'b0, "noop");
        gap(1, "noop_gap");

        for (int k = 0; k < 40; k++) begin
            r = 2'($urandom_range(0, 3));
            do_cmd(r[0], r[1], $sformatf("rnd%0d", k));
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3), "rnd_gap");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
